// File: rtl/store_write_buffer.sv
// store_write_buffer: circular FIFO of committed stores that drains one entry per cycle to the D-cache
// and forwards the youngest matching word to load probes.
module store_write_buffer #(
  parameter int N      = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [$clog2(N+1)-1:0]          ret_count,
  input  logic [N-1:0][ADDR_W-1:0]        ret_addr,
  input  logic [N-1:0][DATA_W-1:0]        ret_data,
  input  logic [N-1:0][DATA_W/8-1:0]      ret_mask,
  output logic [$clog2(N+1)-1:0]          ret_spots,
  output logic                            dc_req_valid,
  output logic [ADDR_W-1:0]               dc_req_addr,
  output logic [DATA_W-1:0]               dc_req_data,
  output logic [DATA_W/8-1:0]             dc_req_mask,
  input  logic                            dc_req_ack,
  input  logic [ADDR_W-1:0]               ld_addr,
  output logic                            ld_hit,
  output logic [DATA_W-1:0]               ld_data,
  output logic [DATA_W/8-1:0]             ld_mask,
  output logic                            empty
);
  localparam int MW  = DATA_W / 8;
  localparam int CW  = $clog2(N + 1);
  localparam int IW  = $clog2(DEPTH);
  localparam int KW  = $clog2(DEPTH + 1);
  localparam int OFF = $clog2(MW);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0][MW-1:0]     mask_q;
  logic [IW-1:0]                head_q, tail_q, idx;
  logic [KW-1:0]                count_q, count_d, free;
  logic [CW-1:0]                acc;
  logic [ADDR_W-1:0]            ld_word;
  logic                         pop;

  assign free         = KW'(DEPTH) - count_q;
  assign ret_spots    = (free < KW'(N)) ? CW'(free) : CW'(N);
  assign acc          = (ret_count > ret_spots) ? ret_spots : ret_count;
  assign pop          = (count_q != '0) && dc_req_ack;
  assign count_d      = count_q + KW'(acc) - KW'(pop);
  assign empty        = (count_q == '0);
  assign dc_req_valid = !empty;
  assign dc_req_addr  = addr_q[head_q];
  assign dc_req_data  = data_q[head_q];
  assign dc_req_mask  = mask_q[head_q];
  assign ld_word      = ld_addr >> OFF;

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    ld_mask = '0;
    idx     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + IW'(k);
      if (KW'(k) < count_q && (addr_q[idx] >> OFF) == ld_word) begin
        ld_hit  = 1'b1;
        ld_data = data_q[idx];
        ld_mask = mask_q[idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      assert (ret_count <= ret_spots)
        else $warning("store_write_buffer: ret_count %0d exceeds ret_spots %0d", ret_count, ret_spots);
      for (int i = 0; i < N; i++)
        if (CW'(i) < acc) begin
          addr_q[tail_q + IW'(i)] <= ret_addr[i];
          data_q[tail_q + IW'(i)] <= ret_data[i];
          mask_q[tail_q + IW'(i)] <= ret_mask[i];
        end
      tail_q  <= tail_q + IW'(acc);
      head_q  <= head_q + IW'(pop);
      count_q <= count_d;
    end
  end
endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter N, default 2: number of stores retired per cycle.
REQ-002 SHALL have parameter DEPTH, default 8 (power of 2, >= N): number of buffer entries.
REQ-003 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-004 SHALL have parameter DATA_W, default 32: store word width; byte mask width is DATA_W/8.
REQ-005 SHALL have port clock, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port ret_count, input, $clog2(N+1): number of retiring stores this cycle, lanes 0..ret_count-1, oldest in lane 0.
REQ-008 SHALL have ports ret_addr, ret_data and ret_mask, input, N x ADDR_W, N x DATA_W and N x DATA_W/8: per-lane retired store address, word data and byte mask.
REQ-009 SHALL have port ret_spots, output, $clog2(N+1): entries acceptable this cycle.
REQ-010 SHALL have ports dc_req_valid, dc_req_addr, dc_req_data and dc_req_mask, outputs, 1, ADDR_W, DATA_W and DATA_W/8: D-cache write request.
REQ-011 SHALL have port dc_req_ack, input, 1: D-cache accepted the current request.
REQ-012 SHALL have port ld_addr, input, ADDR_W: load forwarding probe address.
REQ-013 SHALL have ports ld_hit, ld_data and ld_mask, outputs, 1, DATA_W and DATA_W/8: forwarding result.
REQ-014 SHALL have port empty, output, 1: high when the buffer holds no entries.

Function
REQ-015 SHALL be a circular FIFO with head, tail and count registers; count width $clog2(DEPTH+1); head and tail wrap modulo DEPTH.
REQ-016 SHALL drive ret_spots = min(DEPTH - count, N), combinationally from the registered count only; it SHALL NOT depend on same-cycle dc_req_ack.
REQ-017 SHALL write lane i to entry (tail+i) mod DEPTH at the clock edge for every i < ret_count, and advance tail by ret_count.
REQ-018 SHALL treat ret_count > ret_spots as a protocol violation: it SHALL accept only the first ret_spots lanes and SHALL fire a simulation assertion.
REQ-019 SHALL drive dc_req_valid = (count != 0) and present the head entry on dc_req_addr, dc_req_data and dc_req_mask with zero-cycle latency.
REQ-020 SHALL hold the request fields stable while dc_req_valid=1 and dc_req_ack=0.
REQ-021 SHALL, when dc_req_valid and dc_req_ack are both 1, pop the head at the edge; at most one pop per cycle.
REQ-022 SHALL ignore dc_req_ack when empty.
REQ-023 SHALL update count as count + accepted - popped when push and pop occur in the same cycle, including the full case and the single-entry case.
REQ-024 SHALL compare word addresses only (ld_addr[ADDR_W-1:$clog2(DATA_W/8)]) against every occupied entry, including the head being popped this cycle.
REQ-025 SHALL return, on a match, the youngest matching entry's data and mask with ld_hit=1; otherwise ld_hit=0 and ld_data=ld_mask=0.
REQ-026 SHALL resolve the youngest match by age relative to head, correct across the wrap-around point.
REQ-027 SHALL keep same-cycle retiring stores invisible to forwarding; they are visible from the next cycle.
REQ-028 SHALL drive empty = (count == 0).
REQ-029 SHALL NOT be flushed by branch mispredicts, because contents are architecturally committed.

Reset
REQ-030 SHALL on reset clear head, tail, count and all entry valid state, and drive dc_req_valid=0, ld_hit=0, ld_data=0, ld_mask=0, empty=1 and ret_spots=N.
REQ-031 SHALL give reset priority over simultaneous retire or ack, which are discarded; mid-drain entries are lost.

Verification
REQ-032 SHALL pass this scenario: after reset, ret_count=2 with addr 0x100/0x104, dc_req_ack=0 -> next cycle count=2, dc_req_addr=0x100, ret_spots=2, empty=0.
REQ-033 SHALL pass this scenario: fill 8 entries with ack held low -> ret_spots=0; further ret_count=1 fires the assertion and count stays 8.
REQ-034 SHALL pass this scenario: full buffer, ack=1 and ret_count=0 -> count=7 next cycle, ret_spots=1; then ack=1 with ret_count=1 -> count stays 7.
REQ-035 SHALL pass this scenario: stores to 0x200 (data 0x11, mask 0xF), then 0x202 (data 0xAA00, mask 0x2), probe ld_addr=0x201 -> ld_hit=1, ld_data=0xAA00, ld_mask=0x2.
REQ-036 SHALL pass this scenario: wrap head to index 6, store to 0x300 at index 7, then at index 0 -> probe returns the index-0 entry; the probe SHALL return the same entry in the cycle that index 7 is popped.
REQ-037 SHALL pass this scenario: assert reset while count=5 and ack=1 -> next cycle empty=1, dc_req_valid=0, ret_spots=2.
